// File: rtl/dotl_pkg.sv
// Shared types and constants for the dice / traffic-light generator.
package dotl_pkg;

    typedef enum logic [1:0] {
        RED       = 2'd0,
        RED_AMBER = 2'd1,
        GREEN     = 2'd2,
        AMBER     = 2'd3
    } light_e;

    // Light patterns are {red, amber, green}.
    localparam logic [2:0] LIGHT_RED   = 3'b100;
    localparam logic [2:0] LIGHT_RA    = 3'b110;
    localparam logic [2:0] LIGHT_GREEN = 3'b001;
    localparam logic [2:0] LIGHT_AMBER = 3'b010;

    localparam logic SEL_DICE   = 1'b0;
    localparam logic SEL_LIGHTS = 1'b1;

endpackage

// File: rtl/dotl_lights.sv
// Traffic-light sequencer: state FSM, dwell counter and pedestrian request latch.
module dotl_lights
    import dotl_pkg::*;
#(
    parameter int unsigned RED_CYC       = 8,
    parameter int unsigned RA_CYC        = 2,
    parameter int unsigned GREEN_CYC     = 8,
    parameter int unsigned AMBER_CYC     = 2,
    parameter int unsigned MIN_GREEN_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       button_i,
    output logic [2:0] pattern_o
);

    localparam int unsigned MaxAB  = (RED_CYC > RA_CYC) ? RED_CYC : RA_CYC;
    localparam int unsigned MaxCD  = (GREEN_CYC > AMBER_CYC) ? GREEN_CYC : AMBER_CYC;
    localparam int unsigned MaxCyc = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    light_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ped_q, ped_d;
    logic            dwell_end;
    light_e          state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RED;
            cnt_q   <= '0;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ped_q   <= ped_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ped_d      = ped_q;
        dwell_end  = 1'b0;
        state_next = RED;
        pattern_o  = LIGHT_RED;

        unique case (state_q)
            RED: begin
                dwell_end  = (cnt_q == CntW'(RED_CYC - 1));
                state_next = RED_AMBER;
                pattern_o  = LIGHT_RED;
            end
            RED_AMBER: begin
                dwell_end  = (cnt_q == CntW'(RA_CYC - 1));
                state_next = GREEN;
                pattern_o  = LIGHT_RA;
            end
            GREEN: begin
                // A latched request ends GREEN early, but not before the minimum dwell.
                dwell_end  = (cnt_q == CntW'(GREEN_CYC - 1)) ||
                             (ped_q && (cnt_q >= CntW'(MIN_GREEN_CYC - 1)));
                state_next = AMBER;
                pattern_o  = LIGHT_GREEN;
            end
            AMBER: begin
                dwell_end  = (cnt_q == CntW'(AMBER_CYC - 1));
                state_next = RED;
                pattern_o  = LIGHT_AMBER;
            end
            default: begin
                dwell_end  = 1'b1;
                state_next = RED;
                pattern_o  = LIGHT_RED;
            end
        endcase

        if (en_i) begin
            if (button_i) begin
                ped_d = 1'b1;
            end
            if (dwell_end) begin
                state_d = state_next;
                cnt_d   = '0;
                if (state_next == AMBER) begin
                    ped_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dotl_gen.sv
// Dice / traffic-light generator top: dice counter, lights engine, registered output mux.
// Optional roll counter output enabled by DOTL_ROLL_CNT_EN.
module dotl_gen
    import dotl_pkg::*;
#(
    parameter int unsigned DICE_MAX      = 6,
    parameter int unsigned RESULT_W      = 3,
    parameter int unsigned RED_CYC       = 8,
    parameter int unsigned RA_CYC        = 2,
    parameter int unsigned GREEN_CYC     = 8,
    parameter int unsigned AMBER_CYC     = 2,
    parameter int unsigned MIN_GREEN_CYC = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    input  logic                sel,
    output logic [RESULT_W-1:0] result
`ifdef DOTL_ROLL_CNT_EN
    ,
    output logic [7:0]          rolls
`endif
);

    logic [RESULT_W-1:0] dice_q, dice_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [2:0]          pattern;
    logic                lights_en;

    assign lights_en = (sel == SEL_LIGHTS);

    dotl_lights #(
        .RED_CYC       (RED_CYC),
        .RA_CYC        (RA_CYC),
        .GREEN_CYC     (GREEN_CYC),
        .AMBER_CYC     (AMBER_CYC),
        .MIN_GREEN_CYC (MIN_GREEN_CYC)
    ) u_lights (
        .clk       (clk),
        .rst       (rst),
        .en_i      (lights_en),
        .button_i  (button),
        .pattern_o (pattern)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dice_q   <= RESULT_W'(1);
            result_q <= '0;
        end else begin
            dice_q   <= dice_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        dice_d = dice_q;
        if (sel == SEL_DICE && button) begin
            dice_d = (dice_q == RESULT_W'(DICE_MAX)) ? RESULT_W'(1) : dice_q + 1'b1;
        end
        result_d = lights_en ? RESULT_W'(pattern) : dice_q;
    end

    assign result = result_q;

`ifdef DOTL_ROLL_CNT_EN
    logic       button_q;
    logic [7:0] rolls_q, rolls_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            button_q <= 1'b0;
            rolls_q  <= '0;
        end else begin
            button_q <= button;
            rolls_q  <= rolls_d;
        end
    end

    always_comb begin
        rolls_d = rolls_q;
        if (sel == SEL_DICE && button_q && !button && rolls_q != 8'hFF) begin
            rolls_d = rolls_q + 8'd1;
        end
    end

    assign rolls = rolls_q;
`endif

endmodule
